rgb2hsv_seq: RTL and testbench

Sequential, parametrised RGB-to-HSV converter for the colour-space path: it accepts one unsigned integer RGB pixel per transaction and returns hue, saturation and value in unsigned fixed point. It generalises the combinational floating-point hue stage. It adds pixel-width and precision parameters, a valid/ready handshake, saturation and value outputs, and a single shared multi-cycle divider in place of combinational FP dividers and multipliers.

---
 rtl/rgb2hsv_pkg.sv | 57 +++++
 rtl/rgb2hsv_seq_divider.sv | 79 +++++++
 rtl/rgb2hsv_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_rgb2hsv_seq.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rgb2hsv_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2hsv_pkg
//  Description : Shared types, hue constants and width helpers for the
//                sequential RGB-to-HSV converter.
//  Revision    : 1.0 - initial release
// ============================================================================
package rgb2hsv_pkg;

    // Converter control states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        PREP  = 3'd1,
        DIV_H = 3'd2,
        DIV_S = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Which channel holds Cmax (ties resolve R > G > B)
    typedef enum logic [1:0] {
        SEC_R = 2'd0,
        SEC_G = 2'd1,
        SEC_B = 2'd2
    } sector_t;

    // Hue constants in whole degrees
    localparam int HUE_60  = 60;
    localparam int HUE_120 = 120;
    localparam int HUE_240 = 240;
    localparam int HUE_360 = 360;

    // Hue quotient width: 60*2^F fits in 6+F bits
    function automatic int qh_width(input int frac_w);
        return 6 + frac_w;
    endfunction

    // Saturation quotient width: one extra bit so 1.0 is representable
    function automatic int qs_width(input int s_frac);
        return s_frac + 1;
    endfunction

    // Hue output width: 360*2^F needs 9+F bits
    function automatic int hue_width(input int frac_w);
        return 9 + frac_w;
    endfunction

    // Saturation output width
    function automatic int sat_width(input int s_frac);
        return s_frac + 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rgb2hsv_seq_divider.sv
`default_nettype none
// ============================================================================
//  Module      : seq_divider
//  Description : Restoring unsigned divider producing one quotient bit per
//                cycle. The number of quotient bits is chosen per operation
//                through i_len; the caller guarantees the quotient fits in
//                i_len bits (dividend < divisor * 2^i_len) and DVS_W <= DVD_W.
//                o_done flags the cycle whose closing edge retires the final
//                bit; o_quotient_next is the complete quotient in that cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_divider
    import rgb2hsv_pkg::*;
#(
    parameter int DVD_W = 18,
    parameter int DVS_W = 8,
    parameter int Q_W   = 10,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic [LEN_W-1:0] i_len,
    input  logic [DVD_W-1:0] i_dividend,
    input  logic [DVS_W-1:0] i_divisor,
    output logic             o_done,
    output logic [Q_W-1:0]   o_quotient_next
);

    logic [DVD_W-1:0]     r_rem;
    logic [Q_W-1:0]       r_low;
    logic [DVS_W-1:0]     r_dvs;
    logic [LEN_W-1:0]     r_cnt;

    logic [DVD_W+Q_W-1:0] w_ext;
    logic [DVD_W:0]       w_trial;
    logic [DVD_W:0]       w_dvs_ext;
    logic                 w_ge;
    logic [DVD_W-1:0]     w_diff;
    logic [DVD_W-1:0]     w_rem_next;
    logic [Q_W-1:0]       w_low_next;

    // Split the dividend: bits above the quotient span seed the partial
    // remainder, the low i_len bits are left-aligned in r_low and shifted
    // out one per step while quotient bits fill in from the bottom.
    assign w_ext      = {i_dividend, {Q_W{1'b0}}} >> i_len;

    assign w_trial    = {r_rem, r_low[Q_W-1]};
    assign w_dvs_ext  = (DVD_W+1)'(r_dvs);
    assign w_ge       = (w_trial >= w_dvs_ext);
    // The true difference is below the divisor, so DVD_W bits are enough
    assign w_diff     = w_trial[DVD_W-1:0] - DVD_W'(r_dvs);
    assign w_rem_next = w_ge ? w_diff : w_trial[DVD_W-1:0];
    assign w_low_next = {r_low[Q_W-2:0], w_ge};

    assign o_done          = (r_cnt == LEN_W'(1));
    assign o_quotient_next = w_low_next;

    // Load on start (wins over a final step), otherwise step while bits remain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem <= '0;
            r_low <= '0;
            r_dvs <= '0;
            r_cnt <= '0;
        end else if (i_start) begin
            r_rem <= w_ext[DVD_W+Q_W-1:Q_W];
            r_low <= w_ext[Q_W-1:0];
            r_dvs <= i_divisor;
            r_cnt <= i_len;
        end else if (r_cnt != '0) begin
            r_rem <= w_rem_next;
            r_low <= w_low_next;
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/rgb2hsv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : rgb2hsv_seq
//  Description : Sequential RGB-to-HSV converter with valid/ready handshake.
//                One shared restoring divider computes the hue magnitude and
//                then the saturation; value is Cmax.
//  Revision    : 1.0 - initial release
// ============================================================================
module rgb2hsv_seq
    import rgb2hsv_pkg::*;
#(
    parameter int PIX_W  = 8,
    parameter int FRAC_W = 4,
    parameter int S_FRAC = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [PIX_W-1:0]    r_in,
    input  logic [PIX_W-1:0]    g_in,
    input  logic [PIX_W-1:0]    b_in,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [9+FRAC_W-1:0] h_out,
    output logic [S_FRAC:0]     s_out,
    output logic [PIX_W-1:0]    v_out
);

    localparam int QH    = qh_width(FRAC_W);
    localparam int QS    = qs_width(S_FRAC);
    localparam int HW    = hue_width(FRAC_W);
    localparam int SW    = sat_width(S_FRAC);
    localparam int Q_W   = max_int(QH, QS);
    localparam int LEN_W = $clog2(Q_W + 1);
    localparam int DVD_W = max_int(PIX_W + 6 + FRAC_W, PIX_W + S_FRAC);

    localparam logic [HW-1:0] c_h_full = HW'(HUE_360 << FRAC_W);

    // Control and captured pixel
    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [PIX_W-1:0] r_r;
    logic [PIX_W-1:0] r_g;
    logic [PIX_W-1:0] r_b;

    // Values derived in PREP and kept for the remaining phases
    logic [PIX_W-1:0] r_cmax;
    logic [PIX_W-1:0] r_delta;
    sector_t          r_sector;
    logic             r_neg;
    logic [QH-1:0]    r_hue_q;

    // Output registers
    logic [HW-1:0]    r_h;
    logic [SW-1:0]    r_s;
    logic [PIX_W-1:0] r_v;

    // PREP-stage combinational results
    logic [PIX_W-1:0] w_cmax;
    logic [PIX_W-1:0] w_cmin;
    logic [PIX_W-1:0] w_delta;
    sector_t          w_sector;
    logic             w_neg;
    logic [PIX_W-1:0] w_mag;

    // Divider operand mux
    logic             w_div_start;
    logic             w_div_done;
    logic [LEN_W-1:0] w_div_len;
    logic [DVD_W-1:0] w_div_dvd;
    logic [PIX_W-1:0] w_div_dvs;
    logic [Q_W-1:0]   w_q_next;
    logic [DVD_W-1:0] w_hue_dvd;
    logic [DVD_W-1:0] w_sat_dvd;

    // Final hue / saturation assembly
    logic [HW-1:0]    w_h_base;
    logic [HW-1:0]    w_h_raw;
    logic [HW-1:0]    w_h_final;
    logic [SW-1:0]    w_s_final;

    assign w_cmax  = (r_r >= r_g) ? ((r_r >= r_b) ? r_r : r_b)
                                  : ((r_g >= r_b) ? r_g : r_b);
    assign w_cmin  = (r_r <= r_g) ? ((r_r <= r_b) ? r_r : r_b)
                                  : ((r_g <= r_b) ? r_g : r_b);
    assign w_delta = w_cmax - w_cmin;

    // Pick the sector and form |num| and its sign from the captured pixel
    always_comb begin
        w_sector = SEC_B;
        w_neg    = 1'b0;
        w_mag    = '0;
        if ((r_r >= r_g) && (r_r >= r_b)) begin
            w_sector = SEC_R;
            w_neg    = (r_g < r_b);
            w_mag    = w_neg ? (r_b - r_g) : (r_g - r_b);
        end else if (r_g >= r_b) begin
            w_sector = SEC_G;
            w_neg    = (r_b < r_r);
            w_mag    = w_neg ? (r_r - r_b) : (r_b - r_r);
        end else begin
            w_sector = SEC_B;
            w_neg    = (r_r < r_g);
            w_mag    = w_neg ? (r_g - r_r) : (r_r - r_g);
        end
    end

    assign w_hue_dvd = (DVD_W'(w_mag) * DVD_W'(HUE_60)) << FRAC_W;
    assign w_sat_dvd = DVD_W'(r_delta) << S_FRAC;

    // Hue division is launched from PREP, saturation chains off the last hue step
    assign w_div_start = (r_state == PREP) || ((r_state == DIV_H) && w_div_done);
    assign w_div_dvd   = (r_state == PREP) ? w_hue_dvd : w_sat_dvd;
    assign w_div_dvs   = (r_state == PREP) ? w_delta   : r_cmax;
    assign w_div_len   = (r_state == PREP) ? LEN_W'(QH) : LEN_W'(QS);

    seq_divider #(
        .DVD_W (DVD_W),
        .DVS_W (PIX_W),
        .Q_W   (Q_W),
        .LEN_W (LEN_W)
    ) u_div (
        .clk             (clk),
        .rst             (rst),
        .i_start         (w_div_start),
        .i_len           (w_div_len),
        .i_dividend      (w_div_dvd),
        .i_divisor       (w_div_dvs),
        .o_done          (w_div_done),
        .o_quotient_next (w_q_next)
    );

    // Place the hue magnitude relative to its sector offset; grey pixels give 0
    always_comb begin
        w_h_base = '0;
        case (r_sector)
            SEC_R:   w_h_base = r_neg ? HW'(HUE_360) : '0;
            SEC_G:   w_h_base = HW'(HUE_120);
            default: w_h_base = HW'(HUE_240);
        endcase
        w_h_raw = r_neg ? ((w_h_base << FRAC_W) - HW'(r_hue_q))
                        : ((w_h_base << FRAC_W) + HW'(r_hue_q));
        if ((r_delta == '0) || (w_h_raw == c_h_full)) begin
            w_h_final = '0;
        end else begin
            w_h_final = w_h_raw;
        end
    end

    // Cmax = 0 implies delta = 0, so one test covers both degenerate cases
    assign w_s_final = (r_delta == '0) ? '0 : w_q_next[SW-1:0];

    // Converter FSM with registered handshake flags and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_r         <= '0;
            r_g         <= '0;
            r_b         <= '0;
            r_cmax      <= '0;
            r_delta     <= '0;
            r_sector    <= SEC_R;
            r_neg       <= 1'b0;
            r_hue_q     <= '0;
            r_h         <= '0;
            r_s         <= '0;
            r_v         <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_r        <= r_in;
                        r_g        <= g_in;
                        r_b        <= b_in;
                        r_in_ready <= 1'b0;
                        r_state    <= PREP;
                    end
                end
                PREP: begin
                    r_cmax   <= w_cmax;
                    r_delta  <= w_delta;
                    r_sector <= w_sector;
                    r_neg    <= w_neg;
                    r_state  <= DIV_H;
                end
                DIV_H: begin
                    if (w_div_done) begin
                        r_hue_q <= w_q_next[QH-1:0];
                        r_state <= DIV_S;
                    end
                end
                DIV_S: begin
                    if (w_div_done) begin
                        r_h         <= w_h_final;
                        r_s         <= w_s_final;
                        r_v         <= r_cmax;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign h_out     = r_h;
    assign s_out     = r_s;
    assign v_out     = r_v;

endmodule
`default_nettype wire

// File: tb/tb_rgb2hsv_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rgb2hsv_seq
//  Description : Scoreboard bench for rgb2hsv_seq: a driver pushes expected
//                HSV results from an integer reference model, a monitor pops
//                and compares them whenever a result is presented.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rgb2hsv_seq;

    localparam int PIX_W  = 8;
    localparam int FRAC_W = 4;
    localparam int S_FRAC = 8;
    localparam int QH     = 6 + FRAC_W;
    localparam int QS     = S_FRAC + 1;
    localparam int LAT    = 1 + QH + QS;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic                in_ready;
    logic [PIX_W-1:0]    r_in;
    logic [PIX_W-1:0]    g_in;
    logic [PIX_W-1:0]    b_in;
    logic                out_valid;
    logic                out_ready;
    logic [9+FRAC_W-1:0] h_out;
    logic [S_FRAC:0]     s_out;
    logic [PIX_W-1:0]    v_out;

    typedef struct packed {
        int h;
        int s;
        int v;
        int acc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    rgb2hsv_seq #(
        .PIX_W  (PIX_W),
        .FRAC_W (FRAC_W),
        .S_FRAC (S_FRAC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .r_in      (r_in),
        .g_in      (g_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .h_out     (h_out),
        .s_out     (s_out),
        .v_out     (v_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // HSV straight from the definitions, in plain integer arithmetic
    function automatic exp_t model(input int r, input int g, input int b);
        exp_t e;
        int cmax, cmin, d, num, off, q, mag;
        cmax = (r > g) ? r : g;
        cmax = (b > cmax) ? b : cmax;
        cmin = (r < g) ? r : g;
        cmin = (b < cmin) ? b : cmin;
        d    = cmax - cmin;
        e.v  = cmax;
        e.h  = 0;
        e.s  = 0;
        e.acc = 0;
        if (d != 0) begin
            if (r == cmax) begin
                num = g - b; off = 0;
            end else if (g == cmax) begin
                num = b - r; off = 120;
            end else begin
                num = r - g; off = 240;
            end
            mag = (num < 0) ? -num : num;
            q   = (60 * mag * (1 << FRAC_W)) / d;
            if (num >= 0)      e.h = off * (1 << FRAC_W) + q;
            else if (off == 0) e.h = 360 * (1 << FRAC_W) - q;
            else               e.h = off * (1 << FRAC_W) - q;
            if (e.h == 360 * (1 << FRAC_W)) e.h = 0;
            e.s = (d * (1 << S_FRAC)) / cmax;
        end
        return e;
    endfunction

    // Offer one pixel as soon as the converter is idle; log the expectation
    task automatic send(input int r, input int g, input int b);
        exp_t e;
        int   n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            check("accept_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            r_in = PIX_W'(r);
            g_in = PIX_W'(g);
            b_in = PIX_W'(b);
            e = model(r, g, b);
            @(posedge clk);
            #1;
            e.acc = cyc;
            sb.push_back(e);
            in_valid = 1'b0;
        end
    endtask

    task automatic wait_drain(input bit count_it);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        if (count_it) check("scoreboard_drained", sb.size(), 0);
    endtask

    // Monitor: compare on each new result, then police stability under stall
    bit prev_valid = 1'b0;
    bit exp_ready_next = 1'b0;
    int hold_h, hold_s, hold_v;

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst) begin
            prev_valid     = 1'b0;
            exp_ready_next = 1'b0;
        end else begin
            if (out_valid) begin
                if (!prev_valid) begin
                    if (sb.size() == 0) begin
                        check("unexpected_result", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check("h_out", int'(h_out), e.h);
                        check("s_out", int'(s_out), e.s);
                        check("v_out", int'(v_out), e.v);
                        check("latency", cyc - e.acc, LAT);
                    end
                    hold_h = int'(h_out);
                    hold_s = int'(s_out);
                    hold_v = int'(v_out);
                end else begin
                    check("stall_h_out", int'(h_out), hold_h);
                    check("stall_s_out", int'(s_out), hold_s);
                    check("stall_v_out", int'(v_out), hold_v);
                    check("stall_in_ready", int'(in_ready), 0);
                end
                if (out_ready) exp_ready_next = 1'b1;
            end else if (exp_ready_next) begin
                check("in_ready_after_handshake", int'(in_ready), 1);
                exp_ready_next = 1'b0;
            end
            prev_valid = out_valid;
        end
    end

    initial begin
        int n;
        int r, g, b;
        rst       = 1'b1;
        in_valid  = 1'b0;
        r_in      = '0;
        g_in      = '0;
        b_in      = '0;
        out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", int'(in_ready), 1);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_h_out", int'(h_out), 0);
        check("reset_s_out", int'(s_out), 0);
        check("reset_v_out", int'(v_out), 0);
        @(posedge clk);
        #2 rst = 1'b0;

        // Named colours, ties and greys
        send(255, 0, 0);
        send(0, 255, 0);
        send(100, 50, 200);
        send(200, 100, 150);
        send(255, 255, 0);
        send(128, 128, 128);
        send(0, 0, 0);
        send(0, 0, 255);
        send(0, 255, 255);
        send(255, 0, 255);
        wait_drain(1'b0);

        // Stall the consumer for several cycles in DONE
        out_ready = 1'b0;
        send(30, 200, 90);
        n = 0;
        while (!out_valid && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("stall_result_seen", int'(out_valid), 1);
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
        wait_drain(1'b0);

        // Back-to-back stream with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            send($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        wait_drain(1'b0);

        // Reset during the hue division discards the pixel in flight
        send(10, 20, 30);
        repeat (4) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", int'(out_valid), 0);
        check("midrst_h_out", int'(h_out), 0);
        check("midrst_s_out", int'(s_out), 0);
        check("midrst_v_out", int'(v_out), 0);
        check("midrst_in_ready", int'(in_ready), 1);
        if (sb.size() != 0) void'(sb.pop_back());
        @(posedge clk);
        #2 rst = 1'b0;
        send(60, 180, 30);
        wait_drain(1'b0);

        // Random pixels, with frequent forced channel ties
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 255);
            g = $urandom_range(0, 255);
            b = $urandom_range(0, 255);
            case ($urandom_range(0, 5))
                0: g = r;
                1: b = g;
                2: b = r;
                default: ;
            endcase
            send(r, g, b);
        end
        wait_drain(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
